// File: rtl/frame_buffer_scanout_if.sv
// ---------------------------------------------------------------------------
// frame_buffer_scanout_if
//
// Bundles the scanout block's frame-buffer read port and display pins.
//   read_addr   : scanout -> buffer, read address (buffer read latency 1 clk)
//   pixel_in    : buffer -> scanout, RGB444 data for the previous read_addr
//   vga_r/g/b   : scanout -> display, 4-bit colour channels
//   vga_hsync   : scanout -> display, horizontal sync, active low
//   vga_vsync   : scanout -> display, vertical sync, active low
//   vga_de      : scanout -> display, visible-region data enable
//   frame_start : scanout -> display, one-clock pulse with output pixel (0,0)
//
// master : the scanout block
// slave  : the frame buffer read port together with the display sink
// ---------------------------------------------------------------------------
interface frame_buffer_scanout_if #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] read_addr;
    logic [WIDTH-1:0]  pixel_in;
    logic [3:0]        vga_r;
    logic [3:0]        vga_g;
    logic [3:0]        vga_b;
    logic              vga_hsync;
    logic              vga_vsync;
    logic              vga_de;
    logic              frame_start;

    modport master (
        output read_addr,
        input  pixel_in,
        output vga_r, vga_g, vga_b,
        output vga_hsync, vga_vsync, vga_de, frame_start
    );

    modport slave (
        input  read_addr,
        output pixel_in,
        input  vga_r, vga_g, vga_b,
        input  vga_hsync, vga_vsync, vga_de, frame_start
    );
endinterface

// File: rtl/frame_buffer_scanout.sv
// ---------------------------------------------------------------------------
// frame_buffer_scanout
//
// Reads a SRC_W x SRC_H RGB444 frame buffer and scans it out as VGA timing
// with 2^SCALE_LOG2 nearest-neighbour upscaling on both axes. No line buffer:
// each source line is simply re-read for every output line it covers.
//
// Pipeline (one clock per stage):
//   stage 0 : h/v counters, visible/sync/first-pixel decode
//   stage 1 : registered read_addr plus control flags
//   stage 2 : buffer returns pixel_in; flags delayed once more
//   stage 3 : output registers (rgb, de, syncs, frame_start)
// Counters lead the pins by 3 clocks; read_addr leads vga_de/rgb by 2 clocks.
//
// Ports:
//   clk   : pixel clock, also the frame buffer's read clock
//   rst_n : asynchronous active-low reset
//   bus   : frame buffer read port and display pins (master side)
// ---------------------------------------------------------------------------
module frame_buffer_scanout #(
    parameter int SRC_W      = 80,
    parameter int SRC_H      = 60,
    parameter int WIDTH      = 12,
    parameter int SCALE_LOG2 = 3,
    parameter int H_VIS      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VIS      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                   clk,
    input  logic                   rst_n,
    frame_buffer_scanout_if.master bus
);
    localparam int ADDR_W   = $clog2(SRC_W * SRC_H);
    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    // +1 so the exclusive sync-end bound always fits in the counter width
    localparam int HC_W     = $clog2(H_TOTAL + 1);
    localparam int VC_W     = $clog2(V_TOTAL + 1);
    localparam int MUL_BITS = $clog2(SRC_W + 1);

    localparam logic [31:0]     SRC_W_BITS = 32'(SRC_W);

    localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_VIS_END  = HC_W'(H_VIS);
    localparam logic [HC_W-1:0] H_SYNC_BEG = HC_W'(H_VIS + H_FP);
    localparam logic [HC_W-1:0] H_SYNC_END = HC_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_VIS_END  = VC_W'(V_VIS);
    localparam logic [VC_W-1:0] V_SYNC_BEG = VC_W'(V_VIS + V_FP);
    localparam logic [VC_W-1:0] V_SYNC_END = VC_W'(V_VIS + V_FP + V_SYNC);

    // Flag vector bit positions: {visible, hsync active, vsync active, first}
    localparam int FL_VIS   = 3;
    localparam int FL_HS    = 2;
    localparam int FL_VS    = 1;
    localparam int FL_FIRST = 0;

    // ---------------- stage 0: raster counters ----------------
    logic [HC_W-1:0] h_cnt_reg;
    logic [VC_W-1:0] v_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == H_LAST) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 1'b1;
        end
    end

    logic [3:0] flags_next;
    logic       vis_next;

    always_comb begin
        vis_next             = (h_cnt_reg < H_VIS_END) && (v_cnt_reg < V_VIS_END);
        flags_next           = '0;
        flags_next[FL_VIS]   = vis_next;
        flags_next[FL_HS]    = (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END);
        flags_next[FL_VS]    = (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END);
        flags_next[FL_FIRST] = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    end

    // Source coordinates: dropping the low SCALE_LOG2 bits repeats each source
    // pixel horizontally and each source line vertically.
    logic [ADDR_W-1:0] src_col;
    logic [ADDR_W-1:0] src_row;

    assign src_col = ADDR_W'(h_cnt_reg >> SCALE_LOG2);
    assign src_row = ADDR_W'(v_cnt_reg >> SCALE_LOG2);

    // row * SRC_W as a sum of shifted copies of row, one term per set bit of
    // SRC_W (80 -> row<<6 + row<<4), so no multiplier is inferred.
    logic [ADDR_W-1:0] row_term [MUL_BITS];

    for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_row_mul
        if (SRC_W_BITS[gi]) begin : g_add
            assign row_term[gi] = src_row << gi;
        end else begin : g_zero
            assign row_term[gi] = '0;
        end
    end

    logic [ADDR_W-1:0] addr_next;

    always_comb begin
        addr_next = src_col;
        for (int i = 0; i < MUL_BITS; i++) begin
            addr_next = addr_next + row_term[i];
        end
    end

    // ---------------- stage 1: read address ----------------
    // Blanking reads park on address 0; the data is discarded at stage 3.
    logic [ADDR_W-1:0] addr_reg;
    logic [3:0]        flags1_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg   <= '0;
            flags1_reg <= '0;
        end else begin
            addr_reg   <= vis_next ? addr_next : '0;
            flags1_reg <= flags_next;
        end
    end

    // ---------------- stage 2: wait for buffer data ----------------
    logic [3:0] flags2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags2_reg <= '0;
        end else begin
            flags2_reg <= flags1_reg;
        end
    end

    // ---------------- stage 3: output registers ----------------
    // Sync flags travel active-high through the pipe and are inverted here so
    // the pins idle high, including during reset.
    logic [3:0] r_reg;
    logic [3:0] g_reg;
    logic [3:0] b_reg;
    logic       de_reg;
    logic       hsync_reg;
    logic       vsync_reg;
    logic       frame_start_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg           <= '0;
            g_reg           <= '0;
            b_reg           <= '0;
            de_reg          <= 1'b0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
        end else begin
            // Blanking forces black no matter what the buffer returns.
            r_reg           <= flags2_reg[FL_VIS] ? bus.pixel_in[WIDTH-1 -: 4] : 4'h0;
            g_reg           <= flags2_reg[FL_VIS] ? bus.pixel_in[WIDTH-5 -: 4] : 4'h0;
            b_reg           <= flags2_reg[FL_VIS] ? bus.pixel_in[WIDTH-9 -: 4] : 4'h0;
            de_reg          <= flags2_reg[FL_VIS];
            hsync_reg       <= ~flags2_reg[FL_HS];
            vsync_reg       <= ~flags2_reg[FL_VS];
            frame_start_reg <= flags2_reg[FL_FIRST];
        end
    end

    assign bus.read_addr   = addr_reg;
    assign bus.vga_r       = r_reg;
    assign bus.vga_g       = g_reg;
    assign bus.vga_b       = b_reg;
    assign bus.vga_de      = de_reg;
    assign bus.vga_hsync   = hsync_reg;
    assign bus.vga_vsync   = vsync_reg;
    assign bus.frame_start = frame_start_reg;

endmodule
